// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter between NUM_REQ byte producers. Requesters
// are served round-robin starting after the last owner. The granted byte is
// latched onto tx_data, the transmitter is strobed with tx_drive until it
// reports tx_active, and the arbiter then waits for the frame to end. A short
// idle gap follows every completed frame before the next grant.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   req          per-requester request level, held until granted
//   req_data     byte i on bits [8i+7:8i]
//   gnt          one-hot, one-cycle pulse: byte of that requester accepted
//   done         one-hot, one-cycle pulse: that requester's frame finished
//   tx_drive     start strobe to the transmitter
//   tx_data      byte to the transmitter, stable from grant to frame end
//   tx_active    transmitter busy flag
//   owner        index of the current or last granted requester
//   busy         high in every state except IDLE
//   timeout_err  one-cycle pulse: transmitter never went active
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 2048,
    parameter int GAP_CYCLES    = 16,
    localparam int OW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   tx_drive,
    output logic [7:0]             tx_data,
    input  logic                   tx_active,
    output logic [OW-1:0]          owner,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT_DONE,
        GAP
    } state_t;

    localparam logic [15:0]        TIMEOUT_LAST = 16'(START_TIMEOUT - 1);
    // A zero gap still spends the single GAP cycle that follows done.
    localparam logic [15:0]        GAP_LAST     = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [OW-1:0]      OWNER_RESET  = OW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT      = NUM_REQ'(1);

    state_t               state_q, state_d;
    logic [15:0]          counter_q, counter_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 timeout_q, timeout_d;

    logic [15:0]          counterInc;
    logic [OW-1:0]        sel;
    logic                 found;

    // Saturating increment shared by the DRIVE and GAP counts.
    assign counterInc = (counter_q == 16'hFFFF) ? counter_q : counter_q + 16'd1;

    // Round-robin search: the first pending request after the last owner,
    // wrapping around, so the previous owner is always considered last.
    always_comb begin
        sel   = owner_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(int'(owner_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = OW'((int'(owner_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state logic. Pulsed outputs default low every cycle; tx_data and
    // owner only change when a grant is issued in IDLE.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        gnt_d     = '0;
        done_d    = '0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d   = sel;
                    tx_data_d = req_data[int'(sel)*8 +: 8];
                    gnt_d     = ONE_HOT << sel;
                    counter_d = '0;
                    state_d   = DRIVE;
                end
            end

            DRIVE: begin
                counter_d = counterInc;
                // tx_active has priority over a timeout in the same cycle.
                if (tx_active) begin
                    state_d = WAIT_DONE;
                end else if (counter_q >= TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            WAIT_DONE: begin
                if (!tx_active) begin
                    done_d    = ONE_HOT << owner_q;
                    counter_d = '0;
                    state_d   = GAP;
                end
            end

            GAP: begin
                if (counter_q >= GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    counter_d = counterInc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any frame in flight without
    // a done pulse and hands first priority back to requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            owner_q   <= OWNER_RESET;
            tx_data_q <= 8'h00;
            gnt_q     <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign tx_data     = tx_data_q;
    assign owner       = owner_q;
    assign tx_drive    = (state_q == DRIVE);
    assign busy        = (state_q != IDLE);

endmodule
